// File: rtl/kim_fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
// Define KIM_HAZ_FORWARD_EN for operand forwarding; without it, RAW hazards stall until WB retires.
module kim_fwd_hazard_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH  = 5,
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rt,
    input  logic                       id_uses_rs,
    input  logic                       id_uses_rt,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rd,
    input  logic                       id_reg_write,
    input  logic                       id_mem_read,
    input  logic                       flush,
    input  logic                       ext_stall,
    output logic [1:0]                 fwd_a_sel,
    output logic [1:0]                 fwd_b_sel,
    output logic                       hz_stall,
    output logic                       hz_bubble,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    logic                       ex_v_q, ex_wr_q, ex_ld_q;
    reg_addr_t                  ex_rs_q, ex_rt_q, ex_rd_q;
    logic                       mem_v_q, mem_wr_q;
    reg_addr_t                  mem_rd_q;
    logic                       wb_v_q, wb_wr_q;
    reg_addr_t                  wb_rd_q;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

    logic id_live, ex_hit, hazard;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic writes(input logic v, input logic wr, input reg_addr_t rd,
                                    input reg_addr_t r);
        return v & wr & (rd == r) & (r != '0);
    endfunction

    function automatic logic id_depends(input logic v, input logic wr, input reg_addr_t rd,
                                        input reg_addr_t rs, input logic urs,
                                        input reg_addr_t rt, input logic urt);
        return (urs & writes(v, wr, rd, rs)) | (urt & writes(v, wr, rd, rt));
    endfunction

`ifdef KIM_HAZ_FORWARD_EN
    always_comb begin
        id_live = id_valid & ~flush;
        ex_hit  = id_depends(ex_v_q, ex_wr_q, ex_rd_q, id_rs, id_uses_rs, id_rt, id_uses_rt);
        // Only a load in EX cannot be forwarded in time.
        hazard  = id_live & ex_ld_q & ex_hit;

        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (ex_v_q) begin
            if (writes(mem_v_q, mem_wr_q, mem_rd_q, ex_rs_q)) begin
                fwd_a_sel = 2'b10;
            end else if (writes(wb_v_q, wb_wr_q, wb_rd_q, ex_rs_q)) begin
                fwd_a_sel = 2'b01;
            end
            if (writes(mem_v_q, mem_wr_q, mem_rd_q, ex_rt_q)) begin
                fwd_b_sel = 2'b10;
            end else if (writes(wb_v_q, wb_wr_q, wb_rd_q, ex_rt_q)) begin
                fwd_b_sel = 2'b01;
            end
        end
    end
`else
    logic mem_hit, wb_hit;
    logic unused_ex_fields;

    assign unused_ex_fields = ^{ex_rs_q, ex_rt_q, ex_ld_q};

    always_comb begin
        id_live   = id_valid & ~flush;
        ex_hit    = id_depends(ex_v_q, ex_wr_q, ex_rd_q, id_rs, id_uses_rs, id_rt, id_uses_rt);
        mem_hit   = id_depends(mem_v_q, mem_wr_q, mem_rd_q, id_rs, id_uses_rs, id_rt, id_uses_rt);
        wb_hit    = id_depends(wb_v_q, wb_wr_q, wb_rd_q, id_rs, id_uses_rs, id_rt, id_uses_rt);
        // Without bypass paths the reader waits until its producer has left WB.
        hazard    = id_live & (ex_hit | mem_hit | wb_hit);
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
    end
`endif

    assign hz_stall  = hazard;
    assign hz_bubble = hazard;
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_q      <= 1'b0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_rd_q     <= '0;
            ex_wr_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_v_q     <= 1'b0;
            mem_rd_q    <= '0;
            mem_wr_q    <= 1'b0;
            wb_v_q      <= 1'b0;
            wb_rd_q     <= '0;
            wb_wr_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else if (!ext_stall) begin
            wb_v_q   <= mem_v_q;
            wb_rd_q  <= mem_rd_q;
            wb_wr_q  <= mem_wr_q;
            mem_v_q  <= ex_v_q;
            mem_rd_q <= ex_rd_q;
            mem_wr_q <= ex_wr_q;
            // A squashed or stalled ID instruction enters EX as a bubble.
            ex_v_q   <= id_live & ~hazard;
            ex_rs_q  <= id_rs;
            ex_rt_q  <= id_rt;
            ex_rd_q  <= id_rd;
            ex_wr_q  <= id_reg_write;
            ex_ld_q  <= id_mem_read;
            if (hazard && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_kim_fwd_hazard_ctrl.sv
// Bench for kim_fwd_hazard_ctrl: directed vector table plus random stimulus against a stage model.
// A second instance with a 2-bit counter exercises saturation.
module tb_kim_fwd_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       urs;
        logic       urt;
        logic       wr;
        logic       ld;
    } instr_t;

    typedef struct packed {
        logic       rst;
        logic       tab;
        instr_t     i;
        logic       fl;
        logic       xs;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       ehz;
        logic [7:0] ec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush, ext_stall;
    logic [1:0]  fwd_a_sel, fwd_b_sel, sat_a_sel, sat_b_sel;
    logic        hz_stall, hz_bubble, sat_stall, sat_bubble;
    logic [15:0] stall_cnt;
    logic [1:0]  sat_cnt;

    int checks = 0;
    int errors = 0;

    instr_t      st [3];
    int unsigned m_cnt;
    vec_t        tab [$];

    always #5 clk = ~clk;

    kim_fwd_hazard_ctrl #(.REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .ext_stall(ext_stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .hz_stall(hz_stall), .hz_bubble(hz_bubble), .stall_cnt(stall_cnt)
    );

    kim_fwd_hazard_ctrl #(.REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .ext_stall(ext_stall), .fwd_a_sel(sat_a_sel), .fwd_b_sel(sat_b_sel),
        .hz_stall(sat_stall), .hz_bubble(sat_bubble), .stall_cnt(sat_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic instr_t ins(input logic v, input int rs, input int rt, input int rd,
                                   input logic urs, input logic urt, input logic wr,
                                   input logic ld);
        instr_t r;
        r.v = v; r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
        r.urs = urs; r.urt = urt; r.wr = wr; r.ld = ld;
        return r;
    endfunction

    function automatic vec_t mk(input logic rst, input instr_t i, input logic fl, input logic xs,
                                input logic [1:0] ea, input logic [1:0] eb, input logic ehz,
                                input int ec);
        vec_t t;
        t.rst = rst; t.tab = 1'b1; t.i = i; t.fl = fl; t.xs = xs;
        t.ea = ea; t.eb = eb; t.ehz = ehz; t.ec = 8'(ec);
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        r.v   = ($urandom_range(0, 9) != 0);
        r.rs  = 5'($urandom_range(0, 7));
        r.rt  = 5'($urandom_range(0, 7));
        r.rd  = 5'($urandom_range(0, 7));
        r.urs = ($urandom_range(0, 3) != 0);
        r.urt = ($urandom_range(0, 2) != 0);
        r.wr  = ($urandom_range(0, 3) != 0);
        r.ld  = r.wr && ($urandom_range(0, 2) == 0);
        return r;
    endfunction

    // Reference model: st[0]/st[1]/st[2] are the instructions in EX/MEM/WB.
    task automatic model_reset();
        for (int k = 0; k < 3; k++) st[k] = '0;
        m_cnt = 0;
    endtask

    function automatic logic wr_hit(input instr_t e, input logic [4:0] r);
        return e.v && e.wr && (e.rd == r) && (r != 5'd0);
    endfunction

    function automatic logic reads(input instr_t e, input instr_t i);
        return (i.urs && wr_hit(e, i.rs)) || (i.urt && wr_hit(e, i.rt));
    endfunction

    function automatic logic m_hz(input instr_t i, input logic fl);
        if (!i.v || fl) return 1'b0;
`ifdef KIM_HAZ_FORWARD_EN
        return st[0].ld && reads(st[0], i);
`else
        for (int k = 0; k < 3; k++) if (reads(st[k], i)) return 1'b1;
        return 1'b0;
`endif
    endfunction

    function automatic logic [1:0] m_sel(input logic [4:0] src);
`ifdef KIM_HAZ_FORWARD_EN
        if (!st[0].v) return 2'b00;
        if (wr_hit(st[1], src)) return 2'b10;
        if (wr_hit(st[2], src)) return 2'b01;
`endif
        return (src == 5'd0 && src != 5'd0) ? 2'b11 : 2'b00;
    endfunction

    task automatic drive(input instr_t i, input logic fl, input logic xs);
        id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
        id_uses_rs = i.urs; id_uses_rt = i.urt; id_reg_write = i.wr; id_mem_read = i.ld;
        flush = fl; ext_stall = xs;
    endtask

    task automatic step(input vec_t t, input string tag, output logic hz_m);
        logic [1:0]  ea, eb;
        int unsigned sat_exp;
        if (t.rst) begin
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
            model_reset();
        end
        drive(t.i, t.fl, t.xs);
        @(negedge clk);
        hz_m    = m_hz(t.i, t.fl);
        ea      = m_sel(st[0].rs);
        eb      = m_sel(st[0].rt);
        sat_exp = (m_cnt > 3) ? 3 : m_cnt;
        chk({tag, "_fwd_a"}, 32'(fwd_a_sel), 32'(ea));
        chk({tag, "_fwd_b"}, 32'(fwd_b_sel), 32'(eb));
        chk({tag, "_hz_stall"}, 32'(hz_stall), 32'(hz_m));
        chk({tag, "_hz_bubble"}, 32'(hz_bubble), 32'(hz_m));
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), m_cnt);
        chk({tag, "_sat_cnt"}, 32'(sat_cnt), sat_exp);
        if (t.tab) begin
            chk({tag, "_tab_fwd_a"}, 32'(fwd_a_sel), 32'(t.ea));
            chk({tag, "_tab_fwd_b"}, 32'(fwd_b_sel), 32'(t.eb));
            chk({tag, "_tab_hz"}, 32'(hz_stall), 32'(t.ehz));
            chk({tag, "_tab_cnt"}, 32'(stall_cnt), 32'(t.ec));
        end
        if (!t.xs) begin
            if (hz_m) m_cnt++;
            st[2]    = st[1];
            st[1]    = st[0];
            st[0]    = t.i;
            st[0].v  = t.i.v && !t.fl && !hz_m;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        instr_t nop, add3, sub3, or10, add0, sub0, add5, rd5, lw7, use7, rt_only;
        vec_t   rv;
        logic   hz;

        nop     = ins(0, 0, 0, 0, 0, 0, 0, 0);
        add3    = ins(1, 1, 2, 3, 1, 1, 1, 0);
        sub3    = ins(1, 3, 4, 6, 1, 1, 1, 0);
        or10    = ins(1, 8, 9, 10, 1, 1, 1, 0);
        add0    = ins(1, 1, 2, 0, 1, 1, 1, 0);
        sub0    = ins(1, 0, 4, 6, 1, 0, 1, 0);
        add5    = ins(1, 1, 2, 5, 1, 1, 1, 0);
        rd5     = ins(1, 9, 5, 6, 1, 1, 1, 0);
        lw7     = ins(1, 1, 7, 7, 1, 0, 1, 1);
        use7    = ins(1, 2, 7, 8, 1, 1, 1, 0);
        rt_only = ins(1, 3, 4, 6, 0, 1, 1, 0);

`ifdef KIM_HAZ_FORWARD_EN
        tab.push_back(mk(1, add3, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, sub3, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, nop,  0, 0, 2'b10, 2'b00, 0, 0));
        tab.push_back(mk(1, add3, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, or10, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, sub3, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, nop,  0, 0, 2'b01, 2'b00, 0, 0));
        tab.push_back(mk(1, add0, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, sub0, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, nop,  0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(1, add5, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, add5, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, rd5,  0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, nop,  0, 0, 2'b00, 2'b10, 0, 0));
        tab.push_back(mk(1, lw7,  0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, use7, 0, 0, 2'b00, 2'b00, 1, 0));
        tab.push_back(mk(0, use7, 0, 0, 2'b00, 2'b00, 0, 1));
        tab.push_back(mk(0, nop,  0, 0, 2'b00, 2'b01, 0, 1));
        tab.push_back(mk(1, lw7,  0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, use7, 1, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, nop,  0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(1, lw7,  0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, use7, 0, 1, 2'b00, 2'b00, 1, 0));
        tab.push_back(mk(0, use7, 0, 1, 2'b00, 2'b00, 1, 0));
        tab.push_back(mk(0, use7, 0, 1, 2'b00, 2'b00, 1, 0));
        tab.push_back(mk(0, use7, 0, 0, 2'b00, 2'b00, 1, 0));
        tab.push_back(mk(0, use7, 0, 0, 2'b00, 2'b00, 0, 1));
        tab.push_back(mk(0, nop,  0, 0, 2'b00, 2'b01, 0, 1));
`else
        tab.push_back(mk(1, add3, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, sub3, 0, 0, 2'b00, 2'b00, 1, 0));
        tab.push_back(mk(0, sub3, 0, 0, 2'b00, 2'b00, 1, 1));
        tab.push_back(mk(0, sub3, 0, 0, 2'b00, 2'b00, 1, 2));
        tab.push_back(mk(0, sub3, 0, 0, 2'b00, 2'b00, 0, 3));
        tab.push_back(mk(0, nop,  0, 0, 2'b00, 2'b00, 0, 3));
        tab.push_back(mk(1, add0, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, sub0, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(1, add3, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, sub3, 1, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, sub3, 0, 0, 2'b00, 2'b00, 1, 0));
        tab.push_back(mk(0, sub3, 0, 0, 2'b00, 2'b00, 1, 1));
        tab.push_back(mk(0, sub3, 0, 0, 2'b00, 2'b00, 0, 2));
        tab.push_back(mk(1, add3, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, sub3, 0, 1, 2'b00, 2'b00, 1, 0));
        tab.push_back(mk(0, sub3, 0, 1, 2'b00, 2'b00, 1, 0));
        tab.push_back(mk(0, sub3, 0, 0, 2'b00, 2'b00, 1, 0));
        tab.push_back(mk(0, sub3, 0, 0, 2'b00, 2'b00, 1, 1));
        tab.push_back(mk(0, sub3, 0, 0, 2'b00, 2'b00, 1, 2));
        tab.push_back(mk(0, sub3, 0, 0, 2'b00, 2'b00, 0, 3));
        tab.push_back(mk(1, add3, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, rt_only, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mk(0, ins(0, 3, 3, 6, 1, 1, 1, 0), 0, 0, 2'b00, 2'b00, 0, 0));
`endif

        // Reset held with random inputs: everything stays cleared.
        rst_n = 1'b0;
        model_reset();
        for (int n = 0; n < 4; n++) begin
            drive(rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(negedge clk);
            chk("rst_fwd_a", 32'(fwd_a_sel), 0);
            chk("rst_fwd_b", 32'(fwd_b_sel), 0);
            chk("rst_hz_stall", 32'(hz_stall), 0);
            chk("rst_hz_bubble", 32'(hz_bubble), 0);
            chk("rst_stall_cnt", 32'(stall_cnt), 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        foreach (tab[r]) step(tab[r], $sformatf("row%0d", r), hz);

        // Random phase: IF/ID holds its instruction while stalled or frozen.
        rv     = '0;
        rv.rst = 1'b1;
        rv.i   = rand_instr();
        for (int n = 0; n < 400; n++) begin
            rv.fl = ($urandom_range(0, 9) == 0);
            rv.xs = ($urandom_range(0, 6) == 0);
            step(rv, $sformatf("rnd%0d", n), hz);
            rv.rst = 1'b0;
            if (!rv.xs && !hz) rv.i = rand_instr();
        end

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall_cnt", 32'(stall_cnt), 0);
        chk("async_rst_sat_cnt", 32'(sat_cnt), 0);
        chk("async_rst_hz_stall", 32'(hz_stall), 0);
        chk("async_rst_fwd_a", 32'(fwd_a_sel), 0);
        chk("async_rst_fwd_b", 32'(fwd_b_sel), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 60; n++) begin
            rv.fl = ($urandom_range(0, 9) == 0);
            rv.xs = ($urandom_range(0, 6) == 0);
            step(rv, $sformatf("post%0d", n), hz);
            if (!rv.xs && !hz) rv.i = rand_instr();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kim_fwd_hazard_ctrl.md
Name: kim_fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage pipelined 32-bit MIPS core.
- Keeps a shadow copy of register-usage info for the EX, MEM and WB stages.
- Drives the select lines of the two EX-stage 3:1 operand muxes (sel 00 = register file, 01 = WB result, 10 = MEM result).
- Generates load-use stall and bubble controls for the PC, IF/ID and ID/EX registers.

Parameters:
- REG_ADDR_WIDTH, 5, width of register specifiers.
- STALL_CNT_WIDTH, 16, width of the saturating hazard-stall performance counter.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  REG_ADDR_WIDTH  ID source register A.
- id_rt  input  REG_ADDR_WIDTH  ID source register B.
- id_uses_rs  input  1  instruction reads rs.
- id_uses_rt  input  1  instruction reads rt.
- id_rd  input  REG_ADDR_WIDTH  ID destination register (already muxed rt/rd/31).
- id_reg_write  input  1  instruction writes the register file.
- id_mem_read  input  1  instruction is a load.
- flush  input  1  branch/jump redirect; squashes the instruction in ID.
- ext_stall  input  1  global freeze (memory busy).
- fwd_a_sel  output  2  select for the EX operand A mux.
- fwd_b_sel  output  2  select for the EX operand B mux.
- hz_stall  output  1  hold PC and IF/ID.
- hz_bubble  output  1  load a bubble into ID/EX.
- stall_cnt  output  STALL_CNT_WIDTH  count of hazard-stall cycles.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low on rst_n.
- Reset values: all shadow valid bits 0, shadow addresses 0, stall_cnt 0. Outputs are therefore fwd_a_sel = fwd_b_sel = 00, hz_stall = hz_bubble = 0.
- Reset mid-operation: all state clears immediately, with no dependence on clk.
- Shadow state per stage:
  - EX: ex_v, ex_rs, ex_rt, ex_rd, ex_wr, ex_ld.
  - MEM: mem_v, mem_rd, mem_wr.
  - WB: wb_v, wb_rd, wb_wr.
- Writer predicate: a stage "writes r" iff its valid bit is 1, its wr bit is 1, its rd equals r, and r is nonzero. Register 0 never matches.
- Load-use hazard (combinational): asserted when all of the following hold:
  - ex_v and ex_ld are 1;
  - the EX stage writes id_rs with id_uses_rs set, or writes id_rt with id_uses_rt set;
  - id_valid is 1 and flush is 0.
- hz_stall = hz_bubble = load-use hazard. Flush wins over a hazard: no stall while flush = 1.
- Stage advance on each rising clk edge when ext_stall = 0:
  - WB loads MEM; MEM loads EX.
  - EX loads ID fields, with EX valid = id_valid AND NOT flush AND NOT hz_bubble. A bubble or flush therefore inserts an invalid EX entry.
- When ext_stall = 1, all shadow state holds.
- Forward select for operand A (uses ex_rs; operand B is identical using ex_rt), evaluated only when ex_v = 1, otherwise 00:
  - 10 if the MEM stage writes ex_rs;
  - otherwise 01 if the WB stage writes ex_rs;
  - otherwise 00.
  - MEM has priority over WB. Select 11 is never driven.
- Select outputs are pure functions of registered state; 0-cycle latency relative to the EX stage.
- stall_cnt increments by 1 on each edge where hz_stall = 1 and ext_stall = 0. It saturates at all-ones with no wrap.

Optional Feature:
- Macro: KIM_HAZ_FORWARD_EN.
- Defined: forwarding as described above; only load-use hazards stall, and each stall lasts 1 cycle.
- Undefined:
  - fwd_a_sel and fwd_b_sel are tied to 00.
  - A hazard exists whenever the EX, MEM or WB stage writes a register the ID instruction uses (same id_valid, NOT flush and uses qualifiers).
  - The ID instruction stalls until the writer leaves WB, for up to 3 consecutive cycles.
  - stall_cnt counts every such cycle.
  - Load-use detection is subsumed by this rule.

Test Plan:
- Reset: hold rst_n = 0 with random inputs, then release -> all outputs 0; first instruction enters EX with fwd_a_sel = 00.
- Back-to-back ALU ops: add r3 (rd = 3, reg_write = 1), then sub reading rs = 3 -> next cycle fwd_a_sel = 10. Insert one unrelated instruction in between instead -> fwd_a_sel = 01. Use rd = 0 instead -> fwd_a_sel = 00.
- Priority: r5 written by two consecutive instructions, then read by the third -> fwd_b_sel = 10 (newest writer wins).
- Load-use: lw r7 then add using rt = 7 -> hz_stall = hz_bubble = 1 for exactly 1 cycle, stall_cnt = 1. Next cycle fwd_b_sel = 01.
- Simultaneous events: same load-use pair with flush = 1 in the hazard cycle -> hz_stall = 0 and EX gets a bubble. Same pair with ext_stall = 1 for 3 cycles -> hz_stall is held, state is frozen, stall_cnt remains 0 until ext_stall drops.
- Macro undefined: add r3 then read r3 -> hz_stall high for 3 cycles, sels stay 00, stall_cnt = 3.
